// File: rtl/rggen_axi4lite_slice_if.sv
// AXI4-Lite bundle shared by the slice and the register block.
// master drives requests; slave drives responses.
interface rggen_axi4lite_if #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int BUS_WIDTH     = 32
);
  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid,
    input  awready,
    output awaddr,
    output awprot,
    output wvalid,
    input  wready,
    output wdata,
    output wstrb,
    input  bvalid,
    output bready,
    input  bresp,
    output arvalid,
    input  arready,
    output araddr,
    output arprot,
    input  rvalid,
    output rready,
    input  rdata,
    input  rresp
  );

  modport slave (
    input  awvalid,
    output awready,
    input  awaddr,
    input  awprot,
    input  wvalid,
    output wready,
    input  wdata,
    input  wstrb,
    output bvalid,
    input  bready,
    output bresp,
    input  arvalid,
    output arready,
    input  araddr,
    input  arprot,
    output rvalid,
    input  rready,
    output rdata,
    output rresp
  );
endinterface

// File: rtl/rggen_axi4lite_slice.sv
// AXI4-Lite register slice: one 2-entry skid buffer per channel,
// breaking every valid/ready/payload path between master and block.
module rggen_axi4lite_slice_stage #(
  parameter int WIDTH  = 1,
  parameter bit ENABLE = 1
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [WIDTH-1:0] i_s_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_idle
);
  if (ENABLE) begin : g_reg
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_push;
    logic             w_pop;
    logic             w_ld_main;
    logic             w_ld_skid;
    logic             w_from_skid;

    assign o_s_ready = (r_state != TWO);
    assign o_m_valid = (r_state != EMPTY);
    assign o_m_data  = r_main;
    assign o_idle    = (r_state == EMPTY);
    assign w_push    = i_s_valid & o_s_ready;
    assign w_pop     = o_m_valid & i_m_ready;

    always_comb begin
      w_next      = r_state;
      w_ld_main   = 1'b0;
      w_ld_skid   = 1'b0;
      w_from_skid = 1'b0;
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_next    = ONE;
            w_ld_main = 1'b1;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            w_next    = TWO;
            w_ld_skid = 1'b1;
          end else if (w_push && w_pop) begin
            w_ld_main = 1'b1;
          end else if (w_pop) begin
            w_next = EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_next      = ONE;
            w_from_skid = 1'b1;
          end
        end
        default: w_next = EMPTY;
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= EMPTY;
      end else begin
        r_state <= w_next;
      end
    end

    // payload flops only move when a beat actually moves
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_main <= '0;
        r_skid <= '0;
      end else begin
        if (w_ld_main) begin
          r_main <= i_s_data;
        end else if (w_from_skid) begin
          r_main <= r_skid;
        end
        if (w_ld_skid) begin
          r_skid <= i_s_data;
        end
      end
    end
  end else begin : g_wire
    logic w_unused;
    assign w_unused  = i_clk ^ i_rst_n;
    assign o_m_valid = i_s_valid;
    assign o_s_ready = i_m_ready;
    assign o_m_data  = i_s_data;
    assign o_idle    = 1'b1;
  end
endmodule

module rggen_axi4lite_slice #(
  parameter int ADDRESS_WIDTH  = 7,
  parameter int BUS_WIDTH      = 32,
  parameter bit REQUEST_SLICE  = 1,
  parameter bit RESPONSE_SLICE = 1
)(
  input  logic              i_clk,
  input  logic              i_rst_n,
  rggen_axi4lite_if.slave   slave_if,
  rggen_axi4lite_if.master  master_if,
  output logic              o_idle
);
  localparam int AW_W = ADDRESS_WIDTH + 3;
  localparam int W_W  = BUS_WIDTH + BUS_WIDTH / 8;
  localparam int R_W  = BUS_WIDTH + 2;

  logic [4:0]      w_idle;
  logic [AW_W-1:0] w_aw_m;
  logic [W_W-1:0]  w_w_m;
  logic [AW_W-1:0] w_ar_m;
  logic [R_W-1:0]  w_r_m;

  assign {master_if.awaddr, master_if.awprot} = w_aw_m;
  assign {master_if.wdata, master_if.wstrb}   = w_w_m;
  assign {master_if.araddr, master_if.arprot} = w_ar_m;
  assign {slave_if.rdata, slave_if.rresp}     = w_r_m;
  assign o_idle = &w_idle;

  rggen_axi4lite_slice_stage #(
    .WIDTH  (AW_W),
    .ENABLE (REQUEST_SLICE)
  ) u_aw (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_s_valid (slave_if.awvalid),
    .o_s_ready (slave_if.awready),
    .i_s_data  ({slave_if.awaddr, slave_if.awprot}),
    .o_m_valid (master_if.awvalid),
    .i_m_ready (master_if.awready),
    .o_m_data  (w_aw_m),
    .o_idle    (w_idle[0])
  );

  rggen_axi4lite_slice_stage #(
    .WIDTH  (W_W),
    .ENABLE (REQUEST_SLICE)
  ) u_w (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_s_valid (slave_if.wvalid),
    .o_s_ready (slave_if.wready),
    .i_s_data  ({slave_if.wdata, slave_if.wstrb}),
    .o_m_valid (master_if.wvalid),
    .i_m_ready (master_if.wready),
    .o_m_data  (w_w_m),
    .o_idle    (w_idle[1])
  );

  rggen_axi4lite_slice_stage #(
    .WIDTH  (AW_W),
    .ENABLE (REQUEST_SLICE)
  ) u_ar (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_s_valid (slave_if.arvalid),
    .o_s_ready (slave_if.arready),
    .i_s_data  ({slave_if.araddr, slave_if.arprot}),
    .o_m_valid (master_if.arvalid),
    .i_m_ready (master_if.arready),
    .o_m_data  (w_ar_m),
    .o_idle    (w_idle[2])
  );

  rggen_axi4lite_slice_stage #(
    .WIDTH  (2),
    .ENABLE (RESPONSE_SLICE)
  ) u_b (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_s_valid (master_if.bvalid),
    .o_s_ready (master_if.bready),
    .i_s_data  (master_if.bresp),
    .o_m_valid (slave_if.bvalid),
    .i_m_ready (slave_if.bready),
    .o_m_data  (slave_if.bresp),
    .o_idle    (w_idle[3])
  );

  rggen_axi4lite_slice_stage #(
    .WIDTH  (R_W),
    .ENABLE (RESPONSE_SLICE)
  ) u_r (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_s_valid (master_if.rvalid),
    .o_s_ready (master_if.rready),
    .i_s_data  ({master_if.rdata, master_if.rresp}),
    .o_m_valid (slave_if.rvalid),
    .i_m_ready (slave_if.rready),
    .o_m_data  (w_r_m),
    .o_idle    (w_idle[4])
  );
endmodule
